// File: rtl/alu_seq.sv
// Three-state instruction sequencer for an external combinational ALU, with a 4 x 8 register file.
// Optional zero flag is enabled by defining ZFLAG_EN; otherwise Z is tied low.
module alu_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] INSTR,
    input  logic        IVALID,
    output logic        IREADY,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic [2:0]  ALU_OPR,
    input  logic [7:0]  ALU_R,
    input  logic        ALU_Co,
    input  logic [1:0]  RADDR,
    output logic [7:0]  RDATA,
    output logic        C,
    output logic        Z,
    output logic        DONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  regs_q [4];
    logic [1:0]  rd_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [2:0]  opr_q;
    logic [7:0]  res_q;
    logic        co_q;
    logic        c_q;
    logic        done_q;
    logic        ready_q;
`ifdef ZFLAG_EN
    logic        z_q;
`endif

    // Next-state decode; instructions are accepted only from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (IVALID) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state, operand staging, result capture and write-back.
    // Operands are registered on the accept edge so they are stable for the whole EXEC cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rd_q    <= 2'd0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            opr_q   <= 3'd0;
            res_q   <= 8'h00;
            co_q    <= 1'b0;
            c_q     <= 1'b0;
`ifdef ZFLAG_EN
            z_q     <= 1'b0;
`endif
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            done_q  <= 1'b0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            opr_q   <= 3'd0;
            case (state_q)
                ST_IDLE: begin
                    if (IVALID) begin
                        rd_q  <= INSTR[12:11];
                        a_q   <= regs_q[INSTR[12:11]];
                        b_q   <= INSTR[8] ? INSTR[7:0] : regs_q[INSTR[10:9]];
                        opr_q <= INSTR[15:13];
                    end else begin
                        rd_q  <= rd_q;
                    end
                end
                ST_EXEC: begin
                    res_q  <= ALU_R;
                    co_q   <= ALU_Co;
                    done_q <= 1'b1;
                end
                ST_WB: begin
                    regs_q[rd_q] <= res_q;
                    c_q          <= co_q;
`ifdef ZFLAG_EN
                    z_q          <= (res_q == 8'h00);
`endif
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign IREADY  = ready_q;
    assign ALU_A   = a_q;
    assign ALU_B   = b_q;
    assign ALU_OPR = opr_q;
    assign RDATA   = regs_q[RADDR];
    assign C       = c_q;
    assign DONE    = done_q;
`ifdef ZFLAG_EN
    assign Z       = z_q;
`else
    assign Z       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; provides a small combinational ALU model
// (000 pass B, 001 sub/borrow, 010 add, 011 xor, 100 asr, others and).
module tb_alu_seq;

    logic        clock;
    logic        reset;
    logic [15:0] INSTR;
    logic        IVALID;
    logic        IREADY;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [2:0]  ALU_OPR;
    logic [7:0]  ALU_R;
    logic        ALU_Co;
    logic [1:0]  RADDR;
    logic [7:0]  RDATA;
    logic        C;
    logic        Z;
    logic        DONE;

    int          n_vec;
    int          n_err;
    logic [7:0]  model_reg [4];

    alu_seq dut (
        .clock   (clock),
        .reset   (reset),
        .INSTR   (INSTR),
        .IVALID  (IVALID),
        .IREADY  (IREADY),
        .ALU_A   (ALU_A),
        .ALU_B   (ALU_B),
        .ALU_OPR (ALU_OPR),
        .ALU_R   (ALU_R),
        .ALU_Co  (ALU_Co),
        .RADDR   (RADDR),
        .RDATA   (RDATA),
        .C       (C),
        .Z       (Z),
        .DONE    (DONE)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        ALU_R  = 8'h00;
        ALU_Co = 1'b0;
        case (ALU_OPR)
            3'd0:    ALU_R = ALU_B;
            3'd1:    {ALU_Co, ALU_R} = {1'b0, ALU_A} - {1'b0, ALU_B};
            3'd2:    {ALU_Co, ALU_R} = {1'b0, ALU_A} + {1'b0, ALU_B};
            3'd3:    ALU_R = ALU_A ^ ALU_B;
            3'd4:    begin ALU_R = {ALU_A[7], ALU_A[7:1]}; ALU_Co = ALU_A[0]; end
            default: ALU_R = ALU_A & ALU_B;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        RADDR = addr;
        #1;
        chk(tag, {8'h00, RDATA}, {8'h00, exp});
    endtask

    // One instruction end to end: accept, EXEC operands, WB pulse with old RDATA, then results.
    task automatic run(input logic [15:0] instr, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] eres, input logic ec);
        logic [1:0] rd;
        logic       ez;
        rd = instr[12:11];
`ifdef ZFLAG_EN
        ez = (eres == 8'h00);
`else
        ez = 1'b0;
`endif
        @(negedge clock);
        chk("ready_idle", {15'd0, IREADY}, 16'd1);
        INSTR  = instr;
        IVALID = 1'b1;
        @(posedge clock);
        #1;
        IVALID = 1'b0;
        INSTR  = 16'h0000;
        @(negedge clock);
        chk("exec_ready", {15'd0, IREADY}, 16'd0);
        chk("exec_done", {15'd0, DONE}, 16'd0);
        chk("exec_a", {8'h00, ALU_A}, {8'h00, ea});
        chk("exec_b", {8'h00, ALU_B}, {8'h00, eb});
        chk("exec_opr", {13'd0, ALU_OPR}, {13'd0, instr[15:13]});
        @(negedge clock);
        chk("wb_done", {15'd0, DONE}, 16'd1);
        chk("wb_a_zero", {8'h00, ALU_A}, 16'h0000);
        rd_chk("wb_rdata_old", rd, model_reg[rd]);
        @(negedge clock);
        chk("post_done", {15'd0, DONE}, 16'd0);
        chk("post_ready", {15'd0, IREADY}, 16'd1);
        chk("post_c", {15'd0, C}, {15'd0, ec});
        chk("post_z", {15'd0, Z}, {15'd0, ez});
        rd_chk("post_rdata", rd, eres);
        model_reg[rd] = eres;
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b0;
        INSTR  = 16'h0000;
        IVALID = 1'b0;
        RADDR  = 2'd0;
        for (int i = 0; i < 4; i++) model_reg[i] = 8'h00;

        repeat (2) @(negedge clock);
        chk("rst_ready", {15'd0, IREADY}, 16'd1);
        chk("rst_done", {15'd0, DONE}, 16'd0);
        chk("rst_c", {15'd0, C}, 16'd0);
        chk("rst_z", {15'd0, Z}, 16'd0);
        chk("rst_alu_a", {8'h00, ALU_A}, 16'h0000);
        for (int i = 0; i < 4; i++) rd_chk("rst_reg", i[1:0], 8'h00);
        reset = 1'b1;
        @(negedge clock);
        chk("first_ready", {15'd0, IREADY}, 16'd1);

        run(16'h01F0, 8'h00, 8'hF0, 8'hF0, 1'b0);
        run(16'h4120, 8'hF0, 8'h20, 8'h10, 1'b1);
        run(16'h0B05, 8'h00, 8'h05, 8'h05, 1'b0);
        run(16'h2B06, 8'h05, 8'h06, 8'hFF, 1'b1);
        run(16'h1580, 8'h00, 8'h80, 8'h80, 1'b0);
        run(16'h9400, 8'h80, 8'h80, 8'hC0, 1'b0);
        run(16'h7400, 8'hC0, 8'hC0, 8'h00, 1'b0);
        run(16'hE200, 8'h10, 8'hFF, 8'h10, 1'b0);

        // IVALID held high: only the values present in IDLE cycles execute.
        @(negedge clock);
        INSTR  = 16'h0B33;
        IVALID = 1'b1;
        @(negedge clock);
        chk("cont_exec_ready", {15'd0, IREADY}, 16'd0);
        INSTR = 16'h0577;
        @(negedge clock);
        chk("cont_wb_ready", {15'd0, IREADY}, 16'd0);
        chk("cont_wb_done", {15'd0, DONE}, 16'd1);
        INSTR = 16'h0566;
        @(negedge clock);
        chk("cont_idle_ready", {15'd0, IREADY}, 16'd1);
        chk("cont_idle_done", {15'd0, DONE}, 16'd0);
        rd_chk("cont_reg1", 2'd1, 8'h33);
        INSTR = 16'h1D55;
        @(negedge clock);
        chk("cont_exec2_ready", {15'd0, IREADY}, 16'd0);
        chk("cont_exec2_b", {8'h00, ALU_B}, 16'h0055);
        INSTR = 16'h0599;
        @(negedge clock);
        chk("cont_wb2_done", {15'd0, DONE}, 16'd1);
        IVALID = 1'b0;
        @(negedge clock);
        rd_chk("cont_reg3", 2'd3, 8'h55);
        rd_chk("cont_reg0_kept", 2'd0, 8'h10);
        model_reg[1] = 8'h33;
        model_reg[3] = 8'h55;

        run(16'h2B34, 8'h33, 8'h34, 8'hFF, 1'b1);

        // Reset in the middle of EXEC abandons the instruction.
        @(negedge clock);
        INSTR  = 16'h01AA;
        IVALID = 1'b1;
        @(posedge clock);
        #1;
        IVALID = 1'b0;
        @(negedge clock);
        chk("abort_exec_ready", {15'd0, IREADY}, 16'd0);
        chk("abort_exec_a", {8'h00, ALU_A}, 16'h0010);
        reset = 1'b0;
        #1;
        chk("abort_ready", {15'd0, IREADY}, 16'd1);
        chk("abort_done", {15'd0, DONE}, 16'd0);
        chk("abort_alu_a", {8'h00, ALU_A}, 16'h0000);
        chk("abort_c", {15'd0, C}, 16'd0);
        rd_chk("abort_reg1", 2'd1, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("abort_no_done", {15'd0, DONE}, 16'd0);
            chk("abort_ready_after", {15'd0, IREADY}, 16'd1);
        end
        rd_chk("abort_reg0", 2'd0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 clock  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 INSTR  input  16  instruction: [15:13] OPR, [12:11] RD, [10:9] RS, [8] IMM, [7:0] immediate.
REQ-004 IVALID  input  1  INSTR valid.
REQ-005 IREADY  output  1  sequencer can accept an instruction.
REQ-006 ALU_A, ALU_B  output  8 each  operands driven to the downstream ALU.
REQ-007 ALU_OPR  output  3  operation code driven to the ALU.
REQ-008 ALU_R  input  8  ALU result, combinational from ALU_A/ALU_B/ALU_OPR.
REQ-009 ALU_Co  input  1  ALU carry/borrow.
REQ-010 RADDR  input  2  register-file observation address.
REQ-011 RDATA  output  8  combinational read of reg[RADDR].
REQ-012 C  output  1  registered carry flag.
REQ-013 Z  output  1  registered zero flag (see Configuration).
REQ-014 DONE  output  1  one-cycle pulse on write-back.

Function
REQ-015 Register file SHALL be 4 x 8 bit; one write port, internal operand reads, plus the RDATA port.
REQ-016 FSM states SHALL be IDLE, EXEC, WB.
- IDLE: IREADY=1. IVALID=1 -> latch INSTR, go to EXEC. Otherwise stay.
- EXEC -> WB unconditionally.
- WB -> IDLE unconditionally.
REQ-017 IREADY SHALL be 1 only in IDLE; IVALID in EXEC/WB SHALL be ignored, and the instruction is not latched.
REQ-018 In EXEC: ALU_A = reg[RD]; ALU_B = immediate if IMM=1, else reg[RS]; ALU_OPR = latched OPR. The block SHALL capture ALU_R and ALU_Co at the end of EXEC.
REQ-019 Outside EXEC: ALU_A=0x00, ALU_B=0x00, ALU_OPR=3'b000.
REQ-020 In WB: reg[RD] <= captured result; C <= captured carry; DONE=1 for that cycle only.
REQ-021 Timing: latency from the accept edge to the DONE cycle SHALL be 2 cycles; maximum throughput is 1 instruction per 3 cycles.
REQ-022 RD==RS SHALL be legal: both operands read the same pre-write value.
REQ-023 An RDATA read of reg[RD] in the WB cycle SHALL return the old value; the new value appears the next cycle.
REQ-024 Arithmetic is width-exact 8 bit; results wrap, and overflow is reported only via ALU_Co -> C.
REQ-025 The block SHALL NOT interpret OPR; any 3-bit code is forwarded unchanged.

Reset
REQ-026 reset=0 SHALL immediately force: state IDLE, all 4 registers 0x00, C=0, Z=0, DONE=0, latched instruction 0, capture registers 0.
REQ-027 Reset asserted in EXEC or WB SHALL abandon the instruction: no register write and no DONE.
REQ-028 After reset release, IREADY=1 on the first cycle.

Configuration
REQ-029 Macro ZFLAG_EN:
- Defined: in WB, Z <= (captured result == 0x00).
- Undefined: Z is constant 0 and no zero-detect logic is present.
- C behaviour is identical in both cases.

Verification
REQ-030 After reset, INSTR=0x01F0 (OPR000, RD0, IMM, 0xF0), then INSTR=0x4120 (OPR010, RD0, IMM, 0x20) -> reg0=0x10, C=1, Z=0, one DONE per instruction, 2 cycles after each accept.
REQ-031 reg1=0x05 (via 0x0B05), then INSTR=0x2B06 (OPR001, RD1, IMM, 0x06) -> reg1=0xFF, C=1.
REQ-032 reg2=0x80 (via 0x1580), then INSTR=0x9400 (OPR100, RD2, reg) -> reg2=0xC0, C=0; with ZFLAG_EN, XOR reg2 with itself (INSTR=0x7400, RD2=RS2) -> reg2=0x00, Z=1.
REQ-033 IVALID held high continuously with changing INSTR -> IREADY low in EXEC/WB, and only INSTR values present in IDLE cycles are executed.
REQ-034 Assert reset during EXEC of INSTR=0x01AA -> reg0 stays 0x00, DONE never pulses, and IREADY=1 after release.
